// File: rtl/pc_unit_pkg.sv
// Shared constants for the program-counter unit: FSM state encodings,
// enable levels and an all-zero word used to fill unused data paths.
package pc_unit_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // Enable levels for single-bit controls
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Wide zero word; users slice off the width they need (up to 64 bits)
    localparam logic [63:0] ZERO_WORD = 64'd0;

endpackage : pc_unit_pkg

// File: rtl/pc_unit_ras_stack.sv
// Return-address stack. Circular buffer of DEPTH entries: a push onto a full
// stack overwrites the oldest entry and the occupancy saturates at DEPTH.
// Entry storage is not reset; only the pointer and occupancy are.
module ras_stack
    import pc_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_empty,
    output logic             o_full
);

    localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             CW       = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]  LAST     = PW'(DEPTH - 1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_head;
    logic [CW-1:0]    r_count;
    logic             r_empty;

    logic [PW-1:0]    w_head_inc;
    logic [PW-1:0]    w_head_dec;
    logic [CW-1:0]    w_count_nxt;

    assign w_head_inc = (r_head == LAST)    ? '0   : r_head + PW'(1);
    assign w_head_dec = (r_head == PW'(0))  ? LAST : r_head - PW'(1);

    // Next occupancy: clear wins, push saturates at DEPTH, pop stops at zero
    always_comb begin
        w_count_nxt = r_count;
        if (i_clear) begin
            w_count_nxt = '0;
        end else if (i_push) begin
            if (r_count != FULL_CNT) w_count_nxt = r_count + CW'(1);
        end else if (i_pop) begin
            if (r_count != CW'(0)) w_count_nxt = r_count - CW'(1);
        end
    end

    // Pointer, occupancy and registered empty flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_count <= '0;
            r_empty <= ENABLE;
        end else begin
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == CW'(0));
            if (i_clear) begin
                r_head <= '0;
            end else if (i_push) begin
                r_head <= w_head_inc;
            end else if (i_pop && !r_empty) begin
                r_head <= w_head_dec;
            end
        end
    end

    // Entry storage; contents survive reset on purpose
    always_ff @(posedge clock) begin
        if (i_push && !i_clear) r_mem[w_head_inc] <= i_data;
    end

    // Present zero when empty so an unwritten entry never leaks out
    assign o_top   = r_empty ? ZERO_WORD[WIDTH-1:0] : r_mem[r_head];
    assign o_empty = r_empty;
    assign o_full  = (r_count == FULL_CNT);

endmodule : ras_stack

// File: rtl/pc_unit.sv
// Program-counter unit: BOOT/RUN/HALT sequencer, next-PC selection with
// exception, branch/call, return and stall handling, and a return-address
// stack. All outputs come straight from flops.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                         INST_ADDR_WIDTH = 32,
    parameter int                         INST_BYTES      = 4,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_VECTOR    = '0,
    parameter logic [INST_ADDR_WIDTH-1:0] EXC_VECTOR      = 'h180,
    parameter int                         RAS_DEPTH       = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       halt,
    input  logic                       branchValid,
    input  logic [INST_ADDR_WIDTH-1:0] branchTarget,
    input  logic                       callValid,
    input  logic                       retValid,
    input  logic                       excValid,
    output logic [INST_ADDR_WIDTH-1:0] progCnter,
    output logic                       chipEnable,
    output logic                       rasEmpty,
    output logic                       rasUnderflow
);

    localparam int                         W          = INST_ADDR_WIDTH;
    localparam logic [W-1:0]               STEP       = W'(INST_BYTES);
    localparam logic [W-1:0]               ALIGN_MASK = ~W'(INST_BYTES - 1);

    logic [1:0]   r_state;
    logic [W-1:0] r_pc;
    logic         r_ce;
    logic         r_uf;

    logic [1:0]   w_state_nxt;
    logic [W-1:0] w_pc_nxt;
    logic         w_ce_nxt;
    logic         w_uf_nxt;
    logic         w_push;
    logic         w_pop;
    logic         w_clear;
    logic [W-1:0] w_pc_inc;
    logic [W-1:0] w_target;
    logic [W-1:0] w_top;
    logic         w_empty;
    logic         w_full;

    // Sequential increment wraps naturally at 2^W; redirect targets are aligned
    assign w_pc_inc = r_pc + STEP;
    assign w_target = branchTarget & ALIGN_MASK;

    ras_stack #(
        .WIDTH (W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_data  (w_pc_inc),
        .o_top   (w_top),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Next state / next PC. In RUN: exception, then halt (freezes the PC),
    // then branch/call, then return, then stall, then increment. A halt
    // request beats branch/return so the PC seen at halt stays put.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ce_nxt    = r_ce;
        w_uf_nxt    = DISABLE;
        w_push      = DISABLE;
        w_pop       = DISABLE;
        w_clear     = DISABLE;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
                w_ce_nxt    = ENABLE;
            end
            ST_RUN: begin
                if (excValid) begin
                    w_pc_nxt = EXC_VECTOR;
                    w_clear  = ENABLE;
                end else if (halt) begin
                    w_state_nxt = ST_HALT;
                    w_ce_nxt    = DISABLE;
                end else if (branchValid) begin
                    w_pc_nxt = w_target;
                    w_push   = callValid;
                end else if (retValid) begin
                    if (!w_empty) begin
                        w_pc_nxt = w_top;
                        w_pop    = ENABLE;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                        w_uf_nxt = ENABLE;
                    end
                end else if (!stall) begin
                    w_pc_nxt = w_pc_inc;
                end
            end
            ST_HALT: begin
                if (excValid) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = EXC_VECTOR;
                    w_ce_nxt    = ENABLE;
                    w_clear     = ENABLE;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
                w_pc_nxt    = RESET_VECTOR;
                w_ce_nxt    = DISABLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_VECTOR;
            r_ce    <= DISABLE;
            r_uf    <= DISABLE;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ce    <= w_ce_nxt;
            r_uf    <= w_uf_nxt;
        end
    end

    assign progCnter    = r_pc;
    assign chipEnable   = r_ce;
    assign rasEmpty     = w_empty;
    assign rasUnderflow = r_uf;

endmodule : pc_unit

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter INST_ADDR_WIDTH, default 32, program-counter width in bits.
REQ-002 Parameter INST_BYTES, default 4, increment step; SHALL be a power of two.
REQ-003 Parameter RESET_VECTOR, default 0, first fetch address after reset.
REQ-004 Parameter EXC_VECTOR, default 'h180, exception redirect address.
REQ-005 Parameter RAS_DEPTH, default 4, return-address-stack entries; SHALL be at least 2.
REQ-006 clock  in  1  single clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 stall  in  1  hold the PC this cycle.
REQ-009 halt  in  1  enter HALT.
REQ-010 branchValid  in  1  redirect to branchTarget.
REQ-011 branchTarget  in  INST_ADDR_WIDTH  redirect address.
REQ-012 callValid  in  1  qualifies branchValid; push return address.
REQ-013 retValid  in  1  pop the return-address stack and jump to the popped entry.
REQ-014 excValid  in  1  redirect to EXC_VECTOR.
REQ-015 progCnter  out  INST_ADDR_WIDTH  registered fetch address.
REQ-016 chipEnable  out  1  registered; high only in RUN.
REQ-017 rasEmpty  out  1  stack holds no entries.
REQ-018 rasUnderflow  out  1  one-cycle registered pulse on a pop of an empty stack.

Function
REQ-019 The FSM SHALL have exactly three states: BOOT, RUN and HALT.
REQ-020 BOOT SHALL last exactly one cycle after reset deasserts, with chipEnable=0 and progCnter=RESET_VECTOR, then go to RUN.
REQ-021 In RUN, the next PC SHALL be chosen by this priority:
- excValid
- branchValid
- retValid
- stall (hold)
- increment by INST_BYTES
REQ-022 The increment SHALL wrap modulo 2^INST_ADDR_WIDTH, with no flag.
REQ-023 Redirect targets SHALL have their low log2(INST_BYTES) bits forced to zero.
REQ-024 Any redirect SHALL override stall in the same cycle.
REQ-025 branchValid with callValid SHALL push progCnter+INST_BYTES (wrapped) and load branchTarget in the same edge.
REQ-026 callValid without branchValid SHALL be ignored.
REQ-027 retValid with a non-empty stack SHALL load the top entry and pop it.
REQ-028 retValid with an empty stack SHALL increment normally and pulse rasUnderflow the next cycle.
REQ-029 retValid SHALL be ignored when branchValid or excValid is also high; in that case there is no pop and no underflow pulse.
REQ-030 A push onto a full stack SHALL overwrite the oldest entry, and the depth SHALL stay RAS_DEPTH.
REQ-031 excValid in RUN or HALT SHALL load EXC_VECTOR, empty the stack and enter RUN.
REQ-032 halt in RUN without excValid SHALL enter HALT with progCnter frozen and chipEnable=0 from the next cycle.
REQ-033 HALT SHALL ignore every input except excValid.
REQ-034 All outputs SHALL be registered, with one-cycle latency from input to progCnter.

Reset
REQ-035 Reset assertion at any time SHALL immediately force:
- state=BOOT
- progCnter=RESET_VECTOR
- chipEnable=0
- rasEmpty=1, with the stack pointer cleared
- rasUnderflow=0
REQ-036 Stack entry contents need not be cleared on reset.

Structure
REQ-037 FSM state encodings, ENABLE/DISABLE and ZERO_WORD SHALL live in the shared parameters package.
REQ-038 The return-address stack SHALL be a sub-module, ras_stack, parametrised by width and depth, with push, pop, top, empty and full.

Verification
REQ-039 Release reset -> one cycle with progCnter=0, chipEnable=0, then 0, 4, 8 with chipEnable=1.
REQ-040 In RUN at 0x10: branchValid=1, callValid=1, branchTarget=0x203 -> progCnter=0x200 and stack top=0x14; then retValid -> progCnter=0x14 and rasEmpty=1.
REQ-041 Five calls with RAS_DEPTH=4, then five rets -> the four newest return addresses come back in reverse order; the fifth ret increments and pulses rasUnderflow.
REQ-042 stall=1 with branchValid=1 and excValid=1 -> progCnter=EXC_VECTOR, stack emptied.
REQ-043 INST_ADDR_WIDTH=8 with progCnter=0xFC, no inputs -> next progCnter=0x00.
REQ-044 halt, then retValid and branchValid held for 3 cycles -> progCnter frozen and chipEnable=0; then excValid -> EXC_VECTOR in RUN.
REQ-045 reset asserted mid-cycle -> outputs take reset values before the next clock edge.
